// File: rtl/color_window_sampler.sv
`default_nettype none
// ============================================================================
// color_window_sampler : per-frame RGB average over a square window, optional
// IIR smoothing, and button-driven capture of a reference colour.
// Revision : 1.0  initial release
// ============================================================================
module color_window_sampler #(
    parameter int PIX_W      = 8,
    parameter int HCNT_W     = 12,
    parameter int VCNT_W     = 11,
    parameter int H_START    = 144,
    parameter int V_START    = 104,
    parameter int WIN_LOG2   = 5,
    parameter int FILT_SHIFT = 0
) (
    input  logic                PClk,
    input  logic                rst_n,
    input  logic [HCNT_W-1:0]   VtcHCnt,
    input  logic [VCNT_W-1:0]   VtcVCnt,
    input  logic [3*PIX_W-1:0]  RGB24,
    input  logic                btn_ColorExtract,
    input  logic                sw_ColorClear,
    output logic [3*PIX_W-1:0]  avg_rgb,
    output logic                avg_valid,
    output logic [3*PIX_W-1:0]  RGB_detect,
    output logic                in_window
);

    localparam int                c_N      = 1 << WIN_LOG2;
    localparam int                c_SUM_W  = PIX_W + 2 * WIN_LOG2;
    localparam logic [HCNT_W:0]   c_H_LO   = (HCNT_W+1)'(H_START);
    localparam logic [HCNT_W:0]   c_H_HI   = (HCNT_W+1)'(H_START + c_N);
    localparam logic [VCNT_W:0]   c_V_LO   = (VCNT_W+1)'(V_START);
    localparam logic [VCNT_W:0]   c_V_HI   = (VCNT_W+1)'(V_START + c_N);
    localparam logic [HCNT_W-1:0] c_H_LAST = HCNT_W'(H_START + c_N - 1);
    localparam logic [VCNT_W-1:0] c_V_LAST = VCNT_W'(V_START + c_N - 1);

    typedef enum logic [1:0] {
        ST_WAIT_SOF = 2'd0,
        ST_ACCUM    = 2'd1,
        ST_DONE     = 2'd2
    } state_t;

    state_t               state_q;
    logic [c_SUM_W-1:0]   sum_q  [3];
    logic [c_SUM_W-1:0]   sum_d  [3];
    logic [PIX_W-1:0]     filt_q [3];
    logic [PIX_W-1:0]     filt_d [3];
    logic [PIX_W-1:0]     pix    [3];
    logic [PIX_W-1:0]     raw    [3];
    logic signed [PIX_W:0] diff  [3];
    logic signed [PIX_W:0] step  [3];
    logic signed [PIX_W:0] upd   [3];
    logic                 first_q;
    logic                 row0_q;
    logic                 btn_q;
    logic                 avg_valid_q;
    logic                 in_window_q;
    logic [3*PIX_W-1:0]   detect_q;
    logic                 win_hit;
    logic                 row0;
    logic                 frame_start;
    logic                 last_px;

    assign win_hit = ({1'b0, VtcHCnt} >= c_H_LO) && ({1'b0, VtcHCnt} < c_H_HI) &&
                     ({1'b0, VtcVCnt} >= c_V_LO) && ({1'b0, VtcVCnt} < c_V_HI);
    assign row0        = (VtcVCnt == '0);
    // Row 0 lasts a whole line; only its first cycle starts a new frame.
    assign frame_start = row0 && !row0_q;
    assign last_px     = (VtcHCnt == c_H_LAST) && (VtcVCnt == c_V_LAST);

    always_comb begin
        pix[2] = RGB24[3*PIX_W-1 -: PIX_W];
        pix[1] = RGB24[2*PIX_W-1 -: PIX_W];
        pix[0] = RGB24[PIX_W-1:0];
        for (int c = 0; c < 3; c++) begin
            sum_d[c]  = (frame_start ? '0 : sum_q[c]) + (win_hit ? c_SUM_W'(pix[c]) : '0);
            raw[c]    = sum_d[c][c_SUM_W-1:2*WIN_LOG2];
            diff[c]   = $signed({1'b0, raw[c]}) - $signed({1'b0, filt_q[c]});
            step[c]   = diff[c] >>> FILT_SHIFT;
            upd[c]    = $signed({1'b0, filt_q[c]}) + step[c];
            filt_d[c] = first_q ? raw[c] : upd[c][PIX_W-1:0];
        end
    end

    always_ff @(posedge PClk) begin
        if (!rst_n) begin
            state_q     <= ST_WAIT_SOF;
            first_q     <= 1'b1;
            row0_q      <= 1'b0;
            btn_q       <= 1'b0;
            avg_valid_q <= 1'b0;
            in_window_q <= 1'b0;
            detect_q    <= '1;
            for (int c = 0; c < 3; c++) begin
                sum_q[c]  <= '0;
                filt_q[c] <= '0;
            end
        end else begin
            row0_q      <= row0;
            btn_q       <= btn_ColorExtract;
            in_window_q <= win_hit;
            avg_valid_q <= 1'b0;
            case (state_q)
                ST_WAIT_SOF: begin
                    if (row0) begin
                        state_q <= ST_ACCUM;
                    end
                    for (int c = 0; c < 3; c++) begin
                        sum_q[c] <= row0 ? sum_d[c] : '0;
                    end
                end
                ST_ACCUM: begin
                    // The final pixel is folded in and the result published on the same edge.
                    if (last_px) begin
                        state_q     <= ST_DONE;
                        first_q     <= 1'b0;
                        avg_valid_q <= 1'b1;
                        for (int c = 0; c < 3; c++) begin
                            sum_q[c]  <= '0;
                            filt_q[c] <= filt_d[c];
                        end
                    end else begin
                        for (int c = 0; c < 3; c++) begin
                            sum_q[c] <= sum_d[c];
                        end
                    end
                end
                default: begin
                    state_q <= ST_WAIT_SOF;
                    for (int c = 0; c < 3; c++) begin
                        sum_q[c] <= '0;
                    end
                end
            endcase
            if (sw_ColorClear) begin
                detect_q <= '1;
            end else if (btn_ColorExtract && !btn_q) begin
                detect_q <= avg_rgb;
            end
        end
    end

    assign avg_rgb    = {filt_q[2], filt_q[1], filt_q[0]};
    assign avg_valid  = avg_valid_q;
    assign RGB_detect = detect_q;
    assign in_window  = in_window_q;

endmodule
`default_nettype wire

// File: tb/tb_color_window_sampler.sv
`default_nettype none
// ============================================================================
// tb_color_window_sampler : three differently configured instances checked
// every cycle against a frame-level behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_color_window_sampler;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [11:0] hcnt  [3];
    logic [10:0] vcnt  [3];
    logic [23:0] rgb   [3];
    logic        btn   [3];
    logic        clr   [3];
    logic [23:0] avg   [3];
    logic [23:0] det   [3];
    logic        valid [3];
    logic        inw   [3];

    color_window_sampler u_dut0 (
        .PClk(clk), .rst_n(rst_n), .VtcHCnt(hcnt[0]), .VtcVCnt(vcnt[0]), .RGB24(rgb[0]),
        .btn_ColorExtract(btn[0]), .sw_ColorClear(clr[0]), .avg_rgb(avg[0]),
        .avg_valid(valid[0]), .RGB_detect(det[0]), .in_window(inw[0]));

    color_window_sampler #(.FILT_SHIFT(2)) u_dut1 (
        .PClk(clk), .rst_n(rst_n), .VtcHCnt(hcnt[1]), .VtcVCnt(vcnt[1]), .RGB24(rgb[1]),
        .btn_ColorExtract(btn[1]), .sw_ColorClear(clr[1]), .avg_rgb(avg[1]),
        .avg_valid(valid[1]), .RGB_detect(det[1]), .in_window(inw[1]));

    color_window_sampler #(.WIN_LOG2(3), .H_START(0), .V_START(0)) u_dut2 (
        .PClk(clk), .rst_n(rst_n), .VtcHCnt(hcnt[2]), .VtcVCnt(vcnt[2]), .RGB24(rgb[2]),
        .btn_ColorExtract(btn[2]), .sw_ColorClear(clr[2]), .avg_rgb(avg[2]),
        .avg_valid(valid[2]), .RGB_detect(det[2]), .in_window(inw[2]));

    function automatic int win_hs(input int k); return (k == 2) ? 0 : 144; endfunction
    function automatic int win_vs(input int k); return (k == 2) ? 0 : 104; endfunction
    function automatic int win_n (input int k); return (k == 2) ? 8 : 32;  endfunction
    function automatic int win_fs(input int k); return (k == 1) ? 2 : 0;   endfunction

    // Frame-level model state
    int          m_acc   [3][3];
    int          m_filt  [3][3];
    bit          m_coll  [3];
    bit          m_first [3];
    bit          m_pbtn  [3];
    int          m_prev_v[3];
    logic [23:0] m_det   [3];
    bit          e_valid [3];
    bit          e_inw   [3];
    bit          m_started = 1'b0;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int cnt_valid [3] = '{0, 0, 0};
    int cnt_inw   [3] = '{0, 0, 0};
    int last_px_cyc [3] = '{0, 0, 0};
    int rst_k = -1;
    int rst_h = -1;
    int rst_v = -1;

    function automatic int floordiv(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic logic [23:0] pack(input int k);
        return {8'(m_filt[k][2]), 8'(m_filt[k][1]), 8'(m_filt[k][0])};
    endfunction

    task automatic check(input int k, input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[dut%0d] got %h expected %h at cycle %0d", name, k, got, exp, cyc);
        end
    endtask

    task automatic model_step(input int k);
        int h, v, n, hs, vs, raw;
        bit in_w;
        h  = int'(hcnt[k]);
        v  = int'(vcnt[k]);
        n  = win_n(k);
        hs = win_hs(k);
        vs = win_vs(k);
        in_w = (h >= hs) && (h < hs + n) && (v >= vs) && (v < vs + n);
        if (!rst_n) begin
            m_coll[k] = 0; m_first[k] = 1; m_pbtn[k] = 0; m_prev_v[k] = 1;
            m_det[k] = 24'hFFFFFF; e_valid[k] = 0; e_inw[k] = 0;
            for (int c = 0; c < 3; c++) begin m_filt[k][c] = 0; m_acc[k][c] = 0; end
            return;
        end
        e_inw[k]   = in_w;
        e_valid[k] = 0;
        if (clr[k]) m_det[k] = 24'hFFFFFF;
        else if (btn[k] && !m_pbtn[k]) m_det[k] = pack(k);
        m_pbtn[k] = btn[k];
        if (v == 0 && (!m_coll[k] || m_prev_v[k] != 0)) begin
            m_coll[k] = 1;
            for (int c = 0; c < 3; c++) m_acc[k][c] = 0;
        end
        m_prev_v[k] = v;
        if (m_coll[k] && in_w)
            for (int c = 0; c < 3; c++) m_acc[k][c] += int'(rgb[k][8*c +: 8]);
        if (m_coll[k] && h == hs + n - 1 && v == vs + n - 1) begin
            for (int c = 0; c < 3; c++) begin
                raw = m_acc[k][c] / (n * n);
                if (m_first[k]) m_filt[k][c] = raw;
                else m_filt[k][c] += floordiv(raw - m_filt[k][c], 1 << win_fs(k));
            end
            m_first[k] = 0;
            e_valid[k] = 1;
            m_coll[k]  = 0;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) m_started = 1'b1;
        for (int k = 0; k < 3; k++) model_step(k);
    end

    always @(negedge clk) begin
        if (m_started) begin
            for (int k = 0; k < 3; k++) begin
                check(k, "avg_rgb",    32'(avg[k]),   32'(pack(k)));
                check(k, "avg_valid",  32'(valid[k]), 32'(e_valid[k]));
                check(k, "RGB_detect", 32'(det[k]),   32'(m_det[k]));
                check(k, "in_window",  32'(inw[k]),   32'(e_inw[k]));
                if (valid[k]) begin
                    cnt_valid[k]++;
                    check(k, "valid_latency", 32'(cyc), 32'(last_px_cyc[k] + 1));
                end
                if (inw[k]) cnt_inw[k]++;
            end
        end
    end

    task automatic drive_px(input int k, input int h, input int v, input int mode,
                            input logic [23:0] base, input bit rnd);
        @(negedge clk);
        hcnt[k] = 12'(h);
        vcnt[k] = 11'(v);
        case (mode)
            0:       rgb[k] = base;
            1:       rgb[k] = {8'(h - win_hs(k)), 16'h0000};
            default: rgb[k] = 24'($urandom);
        endcase
        rst_n = (k == rst_k && h == rst_h && v == rst_v) ? 1'b0 : 1'b1;
        if (rnd) begin
            if ($urandom_range(63) == 0) btn[k] = ~btn[k];
            clr[k] = ($urandom_range(127) == 0);
        end
        if (h == win_hs(k) + win_n(k) - 1 && v == win_vs(k) + win_n(k) - 1) last_px_cyc[k] = cyc;
    endtask

    task automatic idle(input int k, input int n);
        repeat (n) drive_px(k, 4095, 2047, 0, 24'h0, 1'b0);
    endtask

    // Compressed frame: row 0, then only the rows/columns around the window.
    task automatic frame(input int k, input int mode, input logic [23:0] base, input bit rnd,
                         input bit no_sof, input int trunc_v);
        int hs, vs, n, h0, vlo;
        hs = win_hs(k); vs = win_vs(k); n = win_n(k);
        h0  = (hs > 2) ? hs - 2 : 0;
        vlo = (vs > 1) ? vs - 1 : 1;
        if (!no_sof)
            for (int h = h0; h <= hs + n + 1; h++) drive_px(k, h, 0, mode, base, rnd);
        for (int v = vlo; v <= vs + n; v++) begin
            if (v == trunc_v) return;
            for (int h = h0; h <= hs + n + 1; h++) drive_px(k, h, v, mode, base, rnd);
        end
        idle(k, 3);
    endtask

    initial begin
        int v0, i0;
        logic [23:0] exp_r1 [4];
        exp_r1 = '{24'h190000, 24'h2B0000, 24'h390000, 24'h2A0000};
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            hcnt[k] = 12'hFFF; vcnt[k] = 11'h7FF; rgb[k] = 24'h0; btn[k] = 1'b0; clr[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check(k, "reset_avg",    32'(avg[k]),   32'h0);
            check(k, "reset_detect", 32'(det[k]),   32'hFFFFFF);
            check(k, "reset_valid",  32'(valid[k]), 32'h0);
            check(k, "reset_inwin",  32'(inw[k]),   32'h0);
        end
        rst_n = 1'b1;

        // Window traversed without a row 0 first: must not produce a result
        frame(0, 0, 24'h4080C0, 0, 1, -1);
        check(0, "no_valid_before_sof", 32'(cnt_valid[0]), 32'd0);
        for (int f = 1; f <= 2; f++) begin
            frame(0, 0, 24'h4080C0, 0, 0, -1);
            check(0, "const_avg",   32'(avg[0]),       32'h4080C0);
            check(0, "valid_count", 32'(cnt_valid[0]), 32'(f));
        end

        // Ramp on red: 496*32/1024 = 15.5 truncated
        i0 = cnt_inw[0];
        frame(0, 1, 24'h0, 0, 0, -1);
        check(0, "ramp_avg",     32'(avg[0]),            32'h0F0000);
        check(0, "inwin_cycles", 32'(cnt_inw[0] - i0),   32'd1024);

        // Capture once while held, clear beats capture
        frame(0, 0, 24'h112233, 0, 0, -1);
        check(0, "cap_src_avg", 32'(avg[0]), 32'h112233);
        btn[0] = 1'b1;
        idle(0, 2);
        check(0, "capture", 32'(det[0]), 32'h112233);
        for (int f = 0; f < 3; f++) begin
            frame(0, 0, 24'h445566, 0, 0, -1);
            check(0, "held_no_recapture", 32'(det[0]), 32'h112233);
        end
        check(0, "avg_after_held", 32'(avg[0]), 32'h445566);
        btn[0] = 1'b0;
        idle(0, 1);
        clr[0] = 1'b1;
        btn[0] = 1'b1;
        idle(0, 1);
        check(0, "clear_beats_capture", 32'(det[0]), 32'hFFFFFF);
        clr[0] = 1'b0;
        btn[0] = 1'b0;
        idle(0, 2);
        check(0, "clear_holds", 32'(det[0]), 32'hFFFFFF);

        // Reset mid-window abandons the partial frame
        v0 = cnt_valid[0];
        rst_k = 0; rst_h = 160; rst_v = 120;
        frame(0, 0, 24'hAA5500, 0, 0, -1);
        rst_k = -1;
        check(0, "no_valid_after_reset", 32'(cnt_valid[0]), 32'(v0));
        frame(0, 0, 24'h123456, 0, 0, -1);
        check(0, "avg_after_reset", 32'(avg[0]),       32'h123456);
        check(0, "valid_after_reset", 32'(cnt_valid[0]), 32'(v0 + 1));

        // IIR with shift 2: 0, 25, 43, 57, then 42
        frame(1, 0, 24'h000000, 0, 0, -1);
        check(1, "iir_first", 32'(avg[1]), 32'h000000);
        for (int f = 0; f < 4; f++) begin
            frame(1, 0, (f < 3) ? 24'h640000 : 24'h000000, 0, 0, -1);
            check(1, "iir_step", 32'(avg[1]), 32'(exp_r1[f]));
        end

        // Small window at origin, full-scale input
        frame(2, 0, 24'hFFFFFF, 0, 0, -1);
        check(2, "small_win_avg",   32'(avg[2]),       32'hFFFFFF);
        check(2, "small_win_valid", 32'(cnt_valid[2]), 32'd1);

        // Truncated frame: restart on the next row 0 with nothing carried over
        v0 = cnt_valid[0];
        frame(0, 2, 24'h0, 0, 0, 110);
        frame(0, 0, 24'h0A0B0C, 0, 0, -1);
        check(0, "trunc_avg",   32'(avg[0]),       32'h0A0B0C);
        check(0, "trunc_valid", 32'(cnt_valid[0]), 32'(v0 + 1));

        // Random pixels with random button/clear activity
        for (int k = 0; k < 3; k++) begin
            repeat (3) frame(k, 2, 24'h0, 1, 0, -1);
            btn[k] = 1'b0;
            clr[k] = 1'b0;
            idle(k, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
